rr_mux_arbiter: RTL
===================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for a 4:1 data mux built as a tree of 2x1 muxes.
- Shares one output channel among four requesters.
- Grants one requester at a time for a burst of up to BURST beats, drives the mux select lines, and handshakes with the downstream consumer via valid/ready.
- Sits between the requester datapaths and the shared output path.

Parameters:
- WIDTH, 8, data width of each input and of out.
- BURST, 4, maximum beats per grant; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- req  input  4  request per requester; bit i belongs to in_i.
- in0  input  WIDTH  requester 0 data.
- in1  input  WIDTH  requester 1 data.
- in2  input  WIDTH  requester 2 data.
- in3  input  WIDTH  requester 3 data.
- out_ready  input  1  downstream can accept a beat this cycle.
- out  output  WIDTH  muxed data; in[sel] while out_valid is 1, else 0.
- out_valid  output  1  beat presented on out.
- gnt  output  4  one-hot grant, all zero when idle.
- sel  output  2  mux select lines {s1,s0} for the 2x1 mux tree.
- busy  output  1  high while in XFER.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State -> IDLE; gnt=0, sel=0, busy=0, out_valid=0, out=0.
  - Beat counter cleared; last-grant pointer = 3, so requester 0 has top priority first.
- States: IDLE, XFER.
- IDLE:
  - If req != 0 at an edge: select the first set bit scanning last+1, last+2, ... (mod 4).
  - Register gnt (one-hot), sel (index), and last=index; clear beat counter; go to XFER.
  - If req == 0: stay in IDLE.
  - Request-to-grant latency is 1 cycle.
- XFER:
  - busy=1; out_valid = req[sel] (combinational); out = in[sel] when out_valid, else 0.
  - A beat occurs at an edge where out_valid && out_ready; the beat counter increments.
  - End of grant, go to IDLE (gnt=0, busy=0), when either:
    - (a) this edge's beat makes the count equal BURST; or
    - (b) req[sel]=0 at an edge (early release; no beat that cycle).
- out_ready=0: hold state, gnt, sel and counter; there is no timeout.
- Exactly one IDLE cycle between grants. A continuously requesting set with out_ready=1 gets BURST cycles of grant then 1 arbitration cycle, i.e. period BURST+1.
- Non-granted req changes during XFER are ignored until the next IDLE evaluation.
- BURST=1: every grant is one beat (or zero on early release), then IDLE.
- Reset mid-XFER: the next cycle shows all reset values; a partial burst is discarded, not resumed.
- gnt is always one-hot or zero; sel always equals the index of the gnt bit while busy.
- Beat counter width: 5 bits (covers 16); it never exceeds BURST.
- in* changes during XFER are passed through combinationally; the arbiter does not register data.

Test Plan:
- Reset then req=0001, out_ready=1, BURST=4, in0=0xA5 -> gnt=0001, sel=0 one cycle after req; out=0xA5 with out_valid=1 for 4 cycles; then gnt=0, busy=0 for 1 cycle; then re-grant requester 0.
- req=1111 held, out_ready=1 -> grant order 0,1,2,3,0; each grant 4 beats; 1 idle cycle between grants; sel follows 0,1,2,3,0.
- req=0100, out_ready toggling 1,0,0,1,1,0,1 -> exactly 4 beats counted only on ready-high edges; grant drops after the 4th beat; gnt/sel stable during stalls.
- req=0010 granted, req[1] dropped after 2 beats -> out_valid=0 immediately, IDLE next edge; next arbitration with req=0011 grants requester 0 (pointer=1, so scan order 2,3,0,1).
- rst_n=0 for one edge during the 2nd beat of a grant to requester 3 -> next cycle gnt=0, sel=0, out_valid=0, busy=0; with req=1000 still high, requester 3 is re-granted with a full fresh burst.
- BURST=1, req=1001, out_ready=1 -> grants alternate 0,3,0,3, each 1 beat with a 1-cycle gap.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that shares one valid/ready output channel among four
// requesters, granting bursts of up to BURST beats through a 2x1 mux tree.
module rr_mux_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             busy
);

    localparam logic [4:0] BURST_L = 5'(BURST);

    typedef enum logic {
        S_IDLE,
        S_XFER
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_gnt;
    logic [3:0]       w_gnt_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic [1:0]       r_last;
    logic [1:0]       w_last_nxt;
    logic [4:0]       r_cnt;
    logic [4:0]       w_cnt_nxt;
    logic [1:0]       w_pick;
    logic             w_busy;
    logic             w_valid;
    logic [WIDTH-1:0] w_m01;
    logic [WIDTH-1:0] w_m23;
    logic [WIDTH-1:0] w_mux;

    // Descending scan so the requester closest after r_last wins; r_last itself is last.
    always_comb begin
        w_pick = r_last;
        for (int k = 4; k >= 1; k--) begin
            if (req[r_last + 2'(k)]) begin
                w_pick = r_last + 2'(k);
            end
        end
    end

    assign w_m01 = r_sel[0] ? in1 : in0;
    assign w_m23 = r_sel[0] ? in3 : in2;
    assign w_mux = r_sel[1] ? w_m23 : w_m01;

    assign w_busy  = (r_state == S_XFER);
    assign w_valid = w_busy & req[r_sel];

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_XFER;
                    w_gnt_nxt   = 4'b0001 << w_pick;
                    w_sel_nxt   = w_pick;
                    w_last_nxt  = w_pick;
                    w_cnt_nxt   = 5'd0;
                end
            end
            S_XFER: begin
                // Early release takes precedence; no beat is possible without req[sel].
                if (!req[r_sel]) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_cnt_nxt   = 5'd0;
                end else if (out_ready) begin
                    if (r_cnt + 5'd1 == BURST_L) begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = 4'b0000;
                        w_cnt_nxt   = 5'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_last  <= 2'd3;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign out       = w_valid ? w_mux : '0;
    assign out_valid = w_valid;
    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign busy      = w_busy;

endmodule
